muldiv_seq: RTL
===============

# muldiv_seq

Multi-cycle sequencer for the RV32M operations that the decoder tags with `m`: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. It sits beside the ALU in the execute stage and accepts one operation at a time. While it works, it drives a stall to the pipeline controller. It returns one 32-bit result with a single-cycle valid pulse. Pipeline flushes abort it without producing a result.

## Interface
- `XLEN`, 32: operand and result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  1  execute stage presents an `m` operation.
- `req_ready`  out  1  sequencer can accept; high only in IDLE.
- `func3`  in  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op_a`  in  32  rs1 value (multiplicand or dividend).
- `op_b`  in  32  rs2 value (multiplier or divisor).
- `flush`  in  1  abort any operation in flight.
- `stall`  out  1  hold upstream stages; high when state is not IDLE and not DONE.
- `resp_valid`  out  1  one-cycle pulse; `resp_data` is valid.
- `resp_data`  out  32  result; holds its last value until the next response.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept: `req_valid & req_ready & !flush`. On accept, latch `func3` and the operand magnitudes, and compute the result sign.
  - MULH: both operands signed.
  - MULHSU: `op_a` signed, `op_b` unsigned.
  - MUL and MULHU: unsigned.
  - DIV and REM: signed.
- Special cases go IDLE→DONE with the result loaded directly:
  - Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = `op_a`.
  - Signed overflow (`op_a`=0x80000000, `op_b`=0xFFFFFFFF) on DIV = 0x80000000; on REM = 0.
- Multiply, in CALC: radix-2 shift-add into a 64-bit accumulator, 32 iterations driven by a 5-bit counter running 0→31.
- Divide, in CALC: restoring division, 32 iterations on a 64-bit remainder/quotient register.
- FIX: conditionally negate the 64-bit product or the quotient/remainder.
  - Select low 32 bits for MUL, high 32 bits for MULH/MULHSU/MULHU.
  - Quotient takes sign a^b; remainder takes the sign of `op_a`.
  - Load `resp_data`.
- DONE: `resp_valid`=1 for one cycle, then go to IDLE.
- Flush in CALC or FIX: go to IDLE on the next edge; no `resp_valid`; `resp_data` is unchanged.
- Flush in DONE: the pulse still fires, because the result was already committed last cycle; the next state is IDLE.
- Flush together with `req_valid` in IDLE: flush wins and the request is not accepted.
- `func3`/`op_a`/`op_b` changing after accept has no effect.

## Timing
- Reset values: state IDLE, `req_ready`=1, `stall`=0, `resp_valid`=0, `resp_data`=0, counter 0.
- Accept edge is cycle 0.
- Iterative path: CALC occupies cycles 1–32, FIX cycle 33, DONE cycle 34. `resp_valid` is high in cycle 34 and `req_ready` returns high in cycle 35.
- Special-case path: DONE in cycle 1, with `resp_valid` in cycle 1.
- `stall` is high in cycles 1–33 of the iterative path and never on the special-case path.
- Back-to-back requests are spaced at least 35 cycles (iterative) or 2 cycles (special case).
- Reset asserted mid-operation: IDLE on the next edge, no response, `resp_data` cleared to 0.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 64-bit signed/unsigned product formed on the latched operands.
  - They go IDLE→DONE with the result registered, giving `resp_valid` in cycle 1 and no stall.
  - Divide is unchanged.
- Not defined: all multiplies take the iterative 34-cycle path. No multiplier array is inferred.

## Test plan
- MUL `op_a`=7, `op_b`=0xFFFFFFFD → `resp_data`=0xFFFFFFEB; `resp_valid` in cycle 34, or cycle 1 with `MULDIV_FAST_MUL_EN`.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; REMU 100/7 → 2. Each has `resp_valid` in cycle 34 and `stall` high in cycles 1–33.
- DIV x/0 → 0xFFFFFFFF, and REMU 5/0 → 5, both in cycle 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, both in cycle 1, with `stall` never high.
- Start DIVU and assert `flush` in cycle 10 → no `resp_valid`; `req_ready`=1 in cycle 11; `resp_data` unchanged. A new request accepted in cycle 11 completes correctly.
- `flush` and `req_valid` in the same IDLE cycle → not accepted and no response. Reset in cycle 20 of a MUL → IDLE with all outputs at reset values in cycle 21.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the RV32M sequencer.
// The master side is the execute stage; the slave side is muldiv_seq.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid, func3, op_a, op_b, flush,
    input  req_ready, stall, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, func3, op_a, op_b, flush,
    output req_ready, stall, resp_valid, resp_data
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q;
  logic        req_ready_q, stall_q, resp_valid_q;
  logic [31:0] resp_data_q;
  logic [4:0]  cnt_q;
  logic [2:0]  func3_q;
  logic [31:0] a_mag_q, b_mag_q;
  logic        neg_q;
  logic [63:0] acc_q, acc_d;

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic n);
    return n ? (~v + 64'd1) : v;
  endfunction

  // Operand conditioning for the request currently on the bus
  logic        accept, is_div, a_sgn, b_sgn, div_zero, div_ovf, special;
  logic [31:0] a_mag, b_mag, special_res;

  assign accept   = bus.req_valid & req_ready_q & ~bus.flush;
  assign is_div   = bus.func3[2];
  assign a_sgn    = bus.op_a[31] & (bus.func3 == 3'd1 || bus.func3 == 3'd2 ||
                                    bus.func3 == 3'd4 || bus.func3 == 3'd6);
  assign b_sgn    = bus.op_b[31] & (bus.func3 == 3'd1 || bus.func3 == 3'd4);
  assign a_mag    = cneg32(bus.op_a, a_sgn);
  assign b_mag    = cneg32(bus.op_b, b_sgn);
  assign div_zero = is_div & (bus.op_b == 32'd0);
  assign div_ovf  = (bus.func3 == 3'd4 || bus.func3 == 3'd6) &&
                    bus.op_a == 32'h8000_0000 && bus.op_b == 32'hFFFF_FFFF;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_prod = cneg64({32'd0, a_mag} * {32'd0, b_mag}, a_sgn ^ b_sgn);
  assign special   = div_zero | div_ovf | ~is_div;
`else
  assign special   = div_zero | div_ovf;
`endif

  always_comb begin
    special_res = 32'd0;
    if (div_zero)     special_res = bus.func3[1] ? bus.op_a : 32'hFFFF_FFFF;
    else if (div_ovf) special_res = bus.func3[1] ? 32'd0 : 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div) special_res = (bus.func3[1:0] == 2'd0) ? fast_prod[31:0] : fast_prod[63:32];
`endif
  end

  // One iteration: shift-add multiply step or restoring divide step
  logic [32:0] mul_sum, rem_sh;
  logic        rem_ge;
  logic [31:0] rem_sub;

  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_mag_q} : 33'd0);
  assign rem_sh  = acc_q[63:31];
  assign rem_ge  = rem_sh >= {1'b0, b_mag_q};
  assign rem_sub = 32'(rem_sh - {1'b0, b_mag_q});

  always_comb begin
    acc_d = acc_q;
    if (func3_q[2]) acc_d = rem_ge ? {rem_sub, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
    else            acc_d = {mul_sum, acc_q[31:1]};
  end

  // Sign fix-up and result select
  logic [63:0] prod_fix;
  logic [31:0] fix_res;

  assign prod_fix = cneg64(acc_q, neg_q);
  always_comb begin
    fix_res = 32'd0;
    if (func3_q[2]) fix_res = func3_q[1] ? cneg32(acc_q[63:32], neg_q) : cneg32(acc_q[31:0], neg_q);
    else            fix_res = (func3_q[1:0] == 2'd0) ? prod_fix[31:0] : prod_fix[63:32];
  end

  // Operand/working registers carry no reset; they are always loaded on accept
  always_ff @(posedge clk) begin
    if (state_q == IDLE && accept) begin
      func3_q <= bus.func3;
      a_mag_q <= a_mag;
      b_mag_q <= b_mag;
      neg_q   <= (bus.func3 == 3'd6) ? a_sgn : (a_sgn ^ b_sgn);
      acc_q   <= is_div ? {32'd0, a_mag} : {32'd0, b_mag};
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      stall_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      cnt_q        <= 5'd0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            cnt_q       <= 5'd0;
            if (special) begin
              resp_data_q  <= special_res;
              resp_valid_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              stall_q <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            stall_q     <= 1'b0;
            cnt_q       <= 5'd0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= FIX;
          end
        end
        FIX: begin
          if (bus.flush) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            stall_q     <= 1'b0;
          end else begin
            resp_data_q  <= fix_res;
            resp_valid_q <= 1'b1;
            stall_q      <= 1'b0;
            state_q      <= DONE;
          end
        end
        DONE: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          stall_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.stall      = stall_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
endmodule
